// File: rtl/mvm_sched.sv
// mvm_sched -- tile scheduler for a matrix-vector-multiply datapath.
//
// Runs a job of i_ntile MVM passes ("tiles"). For each tile it pulses
// o_start_mvm, sweeps the weight-buffer read address across the tile's VLEN
// rows, waits for the datapath's completion level i_ismvm, captures the packed
// result and presents it on a valid/ready handshake. After the last tile is
// transferred it pulses o_done. A job with zero tiles completes immediately.
//
// Optional feature: define MVM_SCHED_TIMEOUT_EN to enable a RUN-state watchdog.
// When TMO RUN cycles pass without i_ismvm, the job is abandoned through ERR
// and the sticky o_err flag is raised. Without the macro, RUN waits forever
// and o_err is constant 0.
//
// Ports:
//   i_clk_sched   clock, all state changes on the rising edge
//   i_rst_sched   asynchronous active-high reset
//   i_req         job request, only looked at while idle
//   i_ntile       tile count of the job, latched when the request is taken
//   o_busy        high whenever the scheduler is not idle
//   o_start_mvm   one-cycle start pulse to the datapath
//   o_w_addr      weight-buffer read address (tile*VLEN + row)
//   i_ismvm       datapath completion level
//   i_wx_result   packed datapath result, element 0 in the LSBs
//   o_res_valid   captured result is being offered
//   i_res_ready   consumer accepts the offered result
//   o_res_data    captured result
//   o_res_tile    tile index belonging to o_res_data
//   o_done        one-cycle job-complete pulse
//   o_err         sticky watchdog error
module mvm_sched #(
    parameter int DW   = 4,
    parameter int VLEN = 4,
    parameter int NT_W = 4,
    parameter int TMO  = 32
) (
    input  logic                            i_clk_sched,
    input  logic                            i_rst_sched,
    input  logic                            i_req,
    input  logic [NT_W-1:0]                 i_ntile,
    output logic                            o_busy,
    output logic                            o_start_mvm,
    output logic [NT_W+$clog2(VLEN)-1:0]    o_w_addr,
    input  logic                            i_ismvm,
    input  logic [VLEN*DW-1:0]              i_wx_result,
    output logic                            o_res_valid,
    input  logic                            i_res_ready,
    output logic [VLEN*DW-1:0]              o_res_data,
    output logic [NT_W-1:0]                 o_res_tile,
    output logic                            o_done,
    output logic                            o_err
);

    localparam int AW = NT_W + $clog2(VLEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]      state_r;
    logic [2:0]      next_state_s;
    logic [NT_W-1:0] tile_r;
    logic [NT_W-1:0] next_tile_s;
    logic [NT_W-1:0] ntile_r;
    logic [AW-1:0]   last_addr_s;
    logic            take_req_s;
    logic            last_tile_s;

`ifdef MVM_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TMO + 1);
    logic [WW-1:0]   wdog_r;
    logic [WW-1:0]   wdog_next_s;
    logic            wdog_hit_s;
`endif

    // First weight row of a tile.
    function automatic logic [AW-1:0] tile_base(input logic [NT_W-1:0] t);
        return AW'(t) * AW'(VLEN);
    endfunction

    // Request acceptance, last-tile detect and the address the RUN sweep stops at.
    always_comb begin
        take_req_s  = (state_r == S_IDLE) && i_req;
        last_tile_s = (tile_r == (ntile_r - {{(NT_W-1){1'b0}}, 1'b1}));
        last_addr_s = tile_base(tile_r) + AW'(VLEN - 1);
    end

`ifdef MVM_SCHED_TIMEOUT_EN
    // Watchdog fires on the TMO-th RUN cycle without completion.
    always_comb begin
        wdog_hit_s = (wdog_r == WW'(TMO - 1));
    end
`endif

    // Next-state, next-tile and watchdog update.
    always_comb begin
        next_state_s = state_r;
        next_tile_s  = tile_r;
`ifdef MVM_SCHED_TIMEOUT_EN
        wdog_next_s  = wdog_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (i_req) begin
                    if (i_ntile != {NT_W{1'b0}}) begin
                        next_state_s = S_START;
                        next_tile_s  = {NT_W{1'b0}};
                    end else begin
                        next_state_s = S_DONE;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_START: begin
                next_state_s = S_RUN;
`ifdef MVM_SCHED_TIMEOUT_EN
                wdog_next_s  = {WW{1'b0}};
`endif
            end
            S_RUN: begin
                if (i_ismvm) begin
                    next_state_s = S_CAPT;
                end else begin
`ifdef MVM_SCHED_TIMEOUT_EN
                    if (wdog_hit_s) begin
                        next_state_s = S_ERR;
                    end else begin
                        wdog_next_s  = wdog_r + WW'(1);
                    end
`else
                    next_state_s = S_RUN;
`endif
                end
            end
            S_CAPT: begin
                next_state_s = S_OUT;
            end
            S_OUT: begin
                if (i_res_ready) begin
                    if (last_tile_s) begin
                        next_state_s = S_DONE;
                    end else begin
                        next_state_s = S_START;
                        next_tile_s  = tile_r + {{(NT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    next_state_s = S_OUT;
                end
            end
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            S_ERR: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs. Outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge i_clk_sched or posedge i_rst_sched) begin
        if (i_rst_sched) begin
            state_r     <= S_IDLE;
            tile_r      <= {NT_W{1'b0}};
            ntile_r     <= {NT_W{1'b0}};
            o_busy      <= 1'b0;
            o_start_mvm <= 1'b0;
            o_w_addr    <= {AW{1'b0}};
            o_res_valid <= 1'b0;
            o_res_data  <= {(VLEN*DW){1'b0}};
            o_res_tile  <= {NT_W{1'b0}};
            o_done      <= 1'b0;
            o_err       <= 1'b0;
`ifdef MVM_SCHED_TIMEOUT_EN
            wdog_r      <= {WW{1'b0}};
`endif
        end else begin
            state_r     <= next_state_s;
            tile_r      <= next_tile_s;
            o_busy      <= (next_state_s != S_IDLE);
            o_start_mvm <= (next_state_s == S_START);
            o_res_valid <= (next_state_s == S_OUT);
            o_done      <= (next_state_s == S_DONE);
`ifdef MVM_SCHED_TIMEOUT_EN
            wdog_r      <= wdog_next_s;
`endif

            if (take_req_s) begin
                ntile_r <= i_ntile;
            end else begin
                ntile_r <= ntile_r;
            end

            // Address: tile base on START, then one row per cycle until the
            // tile's last row, where it parks.
            if (next_state_s == S_START) begin
                o_w_addr <= tile_base(next_tile_s);
            end else if ((next_state_s == S_RUN) && (o_w_addr != last_addr_s)) begin
                o_w_addr <= o_w_addr + AW'(1);
            end else begin
                o_w_addr <= o_w_addr;
            end

            // Result is taken during CAPT and then frozen through OUT.
            if (state_r == S_CAPT) begin
                o_res_data <= i_wx_result;
                o_res_tile <= tile_r;
            end else begin
                o_res_data <= o_res_data;
                o_res_tile <= o_res_tile;
            end

`ifdef MVM_SCHED_TIMEOUT_EN
            if (take_req_s) begin
                o_err <= 1'b0;
            end else if (next_state_s == S_ERR) begin
                o_err <= 1'b1;
            end else begin
                o_err <= o_err;
            end
`else
            o_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mvm_sched.sv
// tb_mvm_sched -- directed and randomized bench for mvm_sched.
// Expected behaviour is derived from the tile protocol: tile t starts at
// address t*VLEN, the address walks one row per RUN cycle up to the tile's
// last row, the result appears two cycles after completion is seen, stays
// frozen while the consumer stalls, and a job ends with a single done pulse.
module tb_mvm_sched;

    localparam int DW   = 4;
    localparam int VLEN = 4;
    localparam int NT_W = 4;
    localparam int TMO  = 32;
    localparam int AW   = NT_W + $clog2(VLEN);
    localparam int RW   = VLEN * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic [NT_W-1:0] ntile = '0;
    logic            ismvm = 1'b0;
    logic [RW-1:0]   wx = '0;
    logic            ready = 1'b0;
    logic            busy, start_mvm, res_valid, done, err;
    logic [AW-1:0]   w_addr;
    logic [RW-1:0]   res_data;
    logic [NT_W-1:0] res_tile;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int dones  = 0;

    mvm_sched #(.DW(DW), .VLEN(VLEN), .NT_W(NT_W), .TMO(TMO)) dut (
        .i_clk_sched (clk),
        .i_rst_sched (rst),
        .i_req       (req),
        .i_ntile     (ntile),
        .o_busy      (busy),
        .o_start_mvm (start_mvm),
        .o_w_addr    (w_addr),
        .i_ismvm     (ismvm),
        .i_wx_result (wx),
        .o_res_valid (res_valid),
        .i_res_ready (ready),
        .o_res_data  (res_data),
        .o_res_tile  (res_tile),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (start_mvm) starts++;
        if (done) dones++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(start_mvm), 32'd0);
        chk({tag, "_addr"}, 32'(w_addr), 32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_data"}, 32'(res_data), 32'd0);
        chk({tag, "_tile"}, 32'(res_tile), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // One job of nt tiles. dfix: RUN cycles before completion minus one
    // (-1 = random); sfix: consumer stall cycles (-1 = random); abort_tile:
    // tile on which reset is pulsed in the first RUN cycle (-1 = none).
    task automatic run_job(input int nt, input int dfix, input int sfix, input int abort_tile,
                           input bit use_data, input logic [RW-1:0] fix_data);
        int s0, d0, d, st, exp_addr;
        logic [RW-1:0] data;
        s0 = starts;
        d0 = dones;
        req = 1'b1;
        ntile = NT_W'(nt);
        tick;
        req = 1'b0;
        ntile = NT_W'($urandom_range(0, 15));
        if (nt == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd1);
            chk("zero_start", 32'(start_mvm), 32'd0);
            tick;
            chk("zero_done_end", 32'(done), 32'd0);
            chk("zero_busy_end", 32'(busy), 32'd0);
            chk("zero_nstarts", 32'(starts - s0), 32'd0);
            chk("zero_ndones", 32'(dones - d0), 32'd1);
            return;
        end
        for (int t = 0; t < nt; t++) begin
            chk("start_pulse", 32'(start_mvm), 32'd1);
            chk("start_base", 32'(w_addr), 32'(t * VLEN));
            chk("start_valid", 32'(res_valid), 32'd0);
            chk("start_err", 32'(err), 32'd0);
            d = (dfix >= 0) ? dfix : $urandom_range(0, 3);
            data = use_data ? fix_data : RW'($urandom);
            wx = data;
            ismvm = 1'b0;
            for (int k = 1; k <= d + 1; k++) begin
                tick;
                req = 1'($urandom_range(0, 1));
                exp_addr = t * VLEN + ((k < VLEN - 1) ? k : VLEN - 1);
                chk("run_addr", 32'(w_addr), 32'(exp_addr));
                chk("run_start", 32'(start_mvm), 32'd0);
                chk("run_busy", 32'(busy), 32'd1);
                if (t == abort_tile) begin
                    #2 rst = 1'b1;
                    #1 chk_all_zero("abort");
                    req = 1'b0;
                    ismvm = 1'b0;
                    tick;
                    rst = 1'b0;
                    return;
                end
                ismvm = (k == d + 1);
            end
            tick;
            ismvm = 1'b0;
            chk("capt_valid", 32'(res_valid), 32'd0);
            tick;
            chk("out_valid", 32'(res_valid), 32'd1);
            chk("out_data", 32'(res_data), 32'(data));
            chk("out_tile", 32'(res_tile), 32'(t));
            wx = RW'($urandom);
            st = (sfix >= 0) ? sfix : $urandom_range(0, 3);
            ready = 1'b0;
            for (int j = 0; j < st; j++) begin
                tick;
                chk("stall_valid", 32'(res_valid), 32'd1);
                chk("stall_data", 32'(res_data), 32'(data));
                chk("stall_tile", 32'(res_tile), 32'(t));
                chk("stall_start", 32'(start_mvm), 32'd0);
            end
            ready = 1'b1;
            tick;
            ready = 1'b0;
        end
        req = 1'b0;
        chk("job_done", 32'(done), 32'd1);
        chk("job_valid_low", 32'(res_valid), 32'd0);
        chk("job_busy", 32'(busy), 32'd1);
        tick;
        chk("job_done_end", 32'(done), 32'd0);
        chk("job_idle", 32'(busy), 32'd0);
        chk("job_nstarts", 32'(starts - s0), 32'(nt));
        chk("job_ndones", 32'(dones - d0), 32'd1);
    endtask

    initial begin
        int s0, d0;
        #2 chk_all_zero("reset");
        tick;
        rst = 1'b0;

        // single tile, completion two cycles after start, fixed data
        run_job(1, 1, 0, -1, 1'b1, 16'h8888);
        // three tiles, consumer always ready
        run_job(3, -1, 0, -1, 1'b0, '0);
        // two tiles, five-cycle consumer stall
        run_job(2, -1, 5, -1, 1'b0, '0);
        // minimum latency on every tile
        run_job(2, 0, 0, -1, 1'b0, '0);
        // empty job
        run_job(0, -1, -1, -1, 1'b0, '0);
        // reset in RUN of tile 1, then a fresh job restarts at tile 0
        run_job(3, -1, 0, 1, 1'b0, '0);
        chk_all_zero("post_abort");
        run_job(1, -1, -1, -1, 1'b0, '0);

        // randomized jobs
        for (int n = 0; n < 8; n++) begin
            run_job($urandom_range(0, 5), -1, -1, -1, 1'b0, '0);
        end

`ifdef MVM_SCHED_TIMEOUT_EN
        // watchdog: completion never arrives
        d0 = dones;
        s0 = starts;
        req = 1'b1;
        ntile = NT_W'(1);
        tick;
        req = 1'b0;
        ismvm = 1'b0;
        chk("tmo_start", 32'(start_mvm), 32'd1);
        repeat (TMO) tick;
        chk("tmo_still_run", 32'(err), 32'd0);
        chk("tmo_still_busy", 32'(busy), 32'd1);
        tick;
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_err_busy", 32'(busy), 32'd1);
        tick;
        chk("tmo_err_hold", 32'(err), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_no_done", 32'(dones - d0), 32'd0);
        chk("tmo_nstarts", 32'(starts - s0), 32'd1);
        run_job(1, -1, -1, -1, 1'b0, '0);
`else
        // no watchdog: a long wait still completes normally
        d0 = dones;
        run_job(1, 40, -1, -1, 1'b0, '0);
        chk("long_wait_err", 32'(err), 32'd0);
        chk("long_wait_done", 32'(dones - d0), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
